// File: rtl/addseq_ctrl.sv
// ---------------------------------------------------------------------------
// addseq_ctrl
// Multi-word carry-chained add sequencer. Wide operands arrive as a stream of
// SIZE-bit words (least-significant first). Each word pair is steered into an
// external combinational adder; the adder's carry-out is registered and fed
// back as carry-in for the next word of the same operation. Result words are
// registered and handed downstream over a valid/ready interface.
//
// Optional feature macro: ADDSEQ_SUB_EN
//   When defined, adds input in_sub. A subtract operation inverts in_b on the
//   way to the adder and forces carry-in to 1 on the first word, so the last
//   word's out_carry is 1 when no borrow occurred.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     upstream handshake for one word pair
//   in_a, in_b            operand words
//   in_first, in_last     word is LS / MS word of an operation
//   in_sub                (ADDSEQ_SUB_EN only) subtract operation
//   add_a, add_b, add_cin drive to the external adder
//   add_sum, add_cout     results from the external adder
//   out_valid/out_ready   downstream handshake for one result word
//   out_sum               registered result word
//   out_last              result word is the MS word
//   out_carry             final carry-out, only on the last word, else 0
//   err                   sticky protocol-error flag, cleared only by reset
// ---------------------------------------------------------------------------
module addseq_ctrl #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic            in_first,
  input  logic            in_last,
`ifdef ADDSEQ_SUB_EN
  input  logic            in_sub,
`endif
  output logic [SIZE-1:0] add_a,
  output logic [SIZE-1:0] add_b,
  output logic            add_cin,
  input  logic [SIZE-1:0] add_sum,
  input  logic            add_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum,
  output logic            out_last,
  output logic            out_carry,
  output logic            err
);

  typedef enum logic {
    IDLE = 1'b0,
    MID  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   carry_q, carry_nxt;
  logic   accept;
  logic   op_start;
  logic   err_set;

`ifdef ADDSEQ_SUB_EN
  logic   sub_q;
`endif

  // A single output register: the upstream side may load it whenever it is
  // empty or being drained in the same cycle, so there is no bubble.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A word starts a fresh carry chain either because we are idle (even if
  // in_first is missing, which is flagged as an error) or because in_first
  // restarts the operation.
  assign op_start = (state == IDLE) || in_first;

  // Adder drive is purely combinational so the adder result is ready to be
  // captured at the same edge the word is accepted.
  always_comb begin
    add_a = in_a;
`ifdef ADDSEQ_SUB_EN
    add_b   = in_sub ? ~in_b : in_b;
    add_cin = op_start ? in_sub : carry_q;
`else
    add_b   = in_b;
    add_cin = op_start ? 1'b0 : carry_q;
`endif
  end

  // Next-state, next-carry and error detection. The carry chain is cleared
  // after the last word so a following single-word op never sees stale carry.
  always_comb begin
    state_nxt = state;
    carry_nxt = carry_q;
    err_set   = 1'b0;
    if (accept) begin
      state_nxt = in_last ? IDLE : MID;
      carry_nxt = in_last ? 1'b0 : add_cout;
      if ((state == IDLE) && !in_first) err_set = 1'b1;
      if ((state == MID) && in_first)   err_set = 1'b1;
`ifdef ADDSEQ_SUB_EN
      if ((state == MID) && (in_sub != sub_q)) err_set = 1'b1;
`endif
    end
  end

  // State and carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      carry_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      carry_q <= carry_nxt;
    end
  end

`ifdef ADDSEQ_SUB_EN
  // Remember the mode of the running operation to spot a mid-op change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= in_sub;
    end
  end
`endif

  // Output register. Data fields only change on accept, so they stay stable
  // while downstream stalls; out_valid drops once the word has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_last  <= in_last;
      out_carry <= in_last ? add_cout : 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_addseq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addseq_ctrl
// Self-checking bench for addseq_ctrl with SIZE=4. A behavioural adder is
// attached to the add_* ports. Expected result words are queued when a word is
// accepted and compared when the DUT hands the word downstream.
// Optional macro: ADDSEQ_SUB_EN (adds the subtract directed case).
// ---------------------------------------------------------------------------
module tb_addseq_ctrl;

  localparam int SIZE = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_a;
  logic [SIZE-1:0] in_b;
  logic            in_first;
  logic            in_last;
`ifdef ADDSEQ_SUB_EN
  logic            in_sub;
`endif
  logic [SIZE-1:0] add_a;
  logic [SIZE-1:0] add_b;
  logic            add_cin;
  logic [SIZE-1:0] add_sum;
  logic            add_cout;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_sum;
  logic            out_last;
  logic            out_carry;
  logic            err;

  typedef struct {
    logic [SIZE-1:0] sum;
    logic            last;
    logic            carry;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   waited;

  addseq_ctrl #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
`ifdef ADDSEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .err       (err)
  );

  // The attached combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SIZE{1'b0}}, add_cin};

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one word pair, wait (bounded) for acceptance, check the carry-in the
  // adder sees and queue the expected result word.
  task automatic applyStimulus(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                               input logic first, input logic last,
                               input logic [SIZE-1:0] exp_sum,
                               input logic exp_carry, input logic exp_cin);
    exp_t e;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    checkOutput("add_cin", {31'd0, add_cin}, {31'd0, exp_cin});
    e.sum   = exp_sum;
    e.last  = last;
    e.carry = exp_carry;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard consumer: a word leaves the DUT when valid and ready coincide.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", sb.size(), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_sum", {28'd0, out_sum}, {28'd0, e.sum});
        checkOutput("out_last", {31'd0, out_last}, {31'd0, e.last});
        checkOutput("out_carry", {31'd0, out_carry}, {31'd0, e.carry});
      end
    end
  end

  // Directed sequence.
  initial begin
    int unsigned a16, b16, tot, mask, cin;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef ADDSEQ_SUB_EN
    in_sub    = 1'b0;
`endif

    // Reset state.
    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_sum", {28'd0, out_sum}, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_out_carry", {31'd0, out_carry}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word 9+8 -> 1 with carry.
    applyStimulus(4'h9, 4'h8, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
    checkOutput("single_err", {31'd0, err}, 32'd0);

    // Two-word F+1 then 0+0: carry ripples into the second word.
    applyStimulus(4'hF, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1);

    // Backpressure: hold the first result, confirm stall, then release.
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(4'h2, 4'h3, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    in_a     = 4'h4;
    in_b     = 4'h5;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_out_sum", {28'd0, out_sum}, 32'd5);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(4'h4, 4'h5, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    checkOutput("bp_same_cycle_accept", waited, 32'd0);

    // Protocol error: idle word without in_first.
    applyStimulus(4'h3, 4'h4, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    checkOutput("err_idle_no_first", {31'd0, err}, 32'd1);

    // Restart inside an operation: carry from the first word is discarded.
    applyStimulus(4'hF, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h2, 4'h3, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);

    // Reset mid-operation after the first of three words.
    applyStimulus(4'hF, 4'hF, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_err", {31'd0, err}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_a     = 4'h1;
    in_b     = 4'h1;
    #1;
    checkOutput("midrst_idle_cin", {31'd0, add_cin}, 32'd0);
    applyStimulus(4'h1, 4'h1, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    checkOutput("midrst_err_after", {31'd0, err}, 32'd0);

    // Random 16-bit additions split into four words.
    for (int n = 0; n < 4; n++) begin
      a16 = $urandom_range(0, 65535);
      b16 = $urandom_range(0, 65535);
      tot = a16 + b16;
      for (int k = 0; k < 4; k++) begin
        mask = (32'd1 << (4 * k)) - 32'd1;
        cin  = (((a16 & mask) + (b16 & mask)) >> (4 * k)) & 32'd1;
        applyStimulus(4'((a16 >> (4 * k)) & 32'hF), 4'((b16 >> (4 * k)) & 32'hF),
                      (k == 0), (k == 3), 4'((tot >> (4 * k)) & 32'hF),
                      (k == 3) ? tot[16] : 1'b0, cin[0]);
      end
    end
    checkOutput("random_err", {31'd0, err}, 32'd0);

`ifdef ADDSEQ_SUB_EN
    // Subtract 0x13 - 0x05 = 0x0E, no borrow.
    in_sub = 1'b1;
    in_b   = 4'h5;
    #1;
    checkOutput("sub_add_b", {28'd0, add_b}, 32'hA);
    applyStimulus(4'h3, 4'h5, 1'b1, 1'b0, 4'hE, 1'b0, 1'b1);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
    checkOutput("sub_err", {31'd0, err}, 32'd0);
    in_sub = 1'b0;
`endif

    // Drain the scoreboard (bounded).
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addseq_ctrl.md
Name: addseq_ctrl

Overview:
- Multi-word carry-chained add sequencer. It sits directly upstream of the combinational size-parameterised adder (ports a, b, cin in; sum, cout out) and consumes that adder's results.
- Accepts wide operands as a stream of SIZE-bit words, least-significant first, and drives each word pair into the adder. The adder's cout is registered and fed back as cin for the next word.
- Registered result words are presented downstream on a valid/ready interface.
- Lets the narrow adder serve arbitrarily wide additions with a fixed pad and area footprint.

Parameters:
- SIZE, 4, width of one operand/result word; must equal the attached adder's size; legal range 1..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word pair valid.
- in_ready  output  1  sequencer can accept a word pair this cycle.
- in_a  input  SIZE  operand A word.
- in_b  input  SIZE  operand B word.
- in_first  input  1  word is least-significant word of an operation.
- in_last  input  1  word is most-significant word of an operation.
- add_a  output  SIZE  to adder a.
- add_b  output  SIZE  to adder b.
- add_cin  output  1  to adder cin.
- add_sum  input  SIZE  from adder sum.
- add_cout  input  1  from adder cout.
- out_valid  output  1  result word valid.
- out_ready  input  1  downstream accepts result word.
- out_sum  output  SIZE  registered result word.
- out_last  output  1  result word is most-significant word.
- out_carry  output  1  final carry-out; meaningful only with out_last, else 0.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync release): all of the following go low or zero.
  - out_valid, out_sum, out_last, out_carry, err.
  - carry register, state = IDLE.
- Adder drive is purely combinational from inputs and state:
  - add_a = in_a, add_b = in_b.
  - add_cin = 0 when state = IDLE or in_first = 1; otherwise add_cin = carry register.
- in_ready = !out_valid || out_ready. This is a single output register with no bubble when downstream is ready.
- Accept occurs when in_valid && in_ready. On accept, at the next clock edge:
  - out_sum <= add_sum.
  - out_last <= in_last.
  - out_carry <= in_last ? add_cout : 0.
  - out_valid <= 1.
  - carry register <= in_last ? 0 : add_cout.
- If no accept and out_ready = 1, out_valid <= 0. All other output registers hold their values.
- out_valid && !out_ready: out_sum, out_last and out_carry are held stable, and in_ready = 0.
- State machine:
  - IDLE: on accept with in_last = 0, go to MID; on accept with in_last = 1, stay in IDLE (single-word operation).
  - MID: on accept with in_last = 1, go to IDLE; on accept with in_last = 0, stay in MID.
- Latency: one cycle from accept to out_valid. Throughput is one word per cycle when out_ready is held high.
- Protocol errors:
  - IDLE with in_first = 0 on accept: word is treated as first (cin 0) and err is set.
  - MID with in_first = 1 on accept: operation restarts (cin 0, carry chain discarded) and err is set.
  - in_first and in_last both set is legal (single word).
- err clears only on reset.
- Arithmetic: per-word result is (in_a + in_b + add_cin) mod 2^SIZE. Carry is exactly add_cout. No internal adder is used; the attached adder's outputs are trusted.
- Reset mid-operation: partial result words already emitted are not recalled. After reset the sequencer is in IDLE and expects in_first.

Optional Feature:
- Macro: ADDSEQ_SUB_EN.
- When defined, the block adds input port in_sub (1 bit), sampled with every word. For a subtract word:
  - add_b = ~in_b.
  - The first word's add_cin = 1 instead of 0.
  - Borrow-free condition is reported as out_carry = 1 on the last word.
- in_sub must be constant across an operation. A change of in_sub in MID sets err; the new value is used.
- When not defined, there is no in_sub port and behaviour is add-only as above.

Test Plan:
- SIZE=4, single word a=9, b=8, first=last=1, out_ready=1 -> one cycle later out_sum=1, out_last=1, out_carry=1, err=0.
- Two-word add: {first a=F, b=1} then {last a=0, b=0} -> out_sum=0 with out_last=0, then out_sum=1 with out_last=1 and out_carry=0 (add_cin=1 on the second word).
- Backpressure: out_ready=0 after the first result -> in_ready=0, out_sum stable for 3 cycles. Release -> next word accepted the same cycle out_ready rises, with no word lost.
- Protocol error: word in IDLE with in_first=0, a=3, b=4 -> out_sum=7, add_cin=0, err=1 and stays set until rst_n low.
- Reset mid-operation: assert rst_n low after the first of three words -> out_valid=0 immediately and state IDLE. The next in_first word uses cin=0.
- ADDSEQ_SUB_EN: in_sub=1, two-word 0x13 - 0x05 ({3,5} then {1,0}) -> out_sum=E, then 0, with out_carry=1 (no borrow).
